// File: rtl/brqrv_loader_pkg.sv
// Shared types and constants for the UART program loader.
package brqrv_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } load_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Bytes in the length header and in each image word.
    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, framing check.
module uart_rx_byte
    import brqrv_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             half_tick;
    logic             bit_tick;

    // Two-flop synchronizer; resets to the idle (high) line level.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
        end
    end

    // RX state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // RX next-state: false start check at half bit, 8 data bits, then stop bit.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_sync) state_d = START;
            START:   if (half_tick) state_d = rx_sync ? IDLE : DATA;
            DATA:    if (bit_tick && bit_q == 3'd7) state_d = STOP;
            STOP:    if (bit_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample strobes derived from the bit timer.
    always_comb begin
        half_tick = (state_q == START) && (cnt_q == HALF_LAST);
        bit_tick  = ((state_q == DATA) || (state_q == STOP)) && (cnt_q == FULL_LAST);
    end

    // Bit timer, bit index and the one-cycle result pulses.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            if ((state_q == IDLE) || half_tick || bit_tick) cnt_q <= '0;
            else                                            cnt_q <= cnt_q + 1'b1;
            if (half_tick) bit_q <= '0;
            if (bit_tick && (state_q == DATA)) bit_q <= bit_q + 1'b1;
            if (bit_tick && (state_q == STOP)) begin
                byte_valid_o <= rx_sync;
                frame_err_o  <= ~rx_sync;
            end
        end
    end

    // Data shift register, LSB first.
    // NOTE: pure data qualified by a valid strobe needs no reset.
    always_ff @(posedge wb_clk_i) begin
        if (bit_tick && (state_q == DATA)) shift_q <= {rx_sync, shift_q[7:1]};
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: assembles LE words from a length-prefixed image and
// writes them into instruction memory, then releases the core reset.
module uart_prog_loader
    import brqrv_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int ADDR_W       = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              uart_rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic              core_rst_o,
    output logic              prog_done_o,
    output logic              frame_err_o,
    output logic              overrun_err_o,
    output logic              len_err_o
);

    localparam logic [32:0] CAPACITY  = 33'(1) << ADDR_W;
    localparam logic [1:0]  LEN_LAST  = 2'(LEN_BYTES - 1);
    localparam logic [1:0]  WORD_LAST = 2'(WORD_BYTES - 1);

    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_frame_err;

    logic            buf_full;
    logic [7:0]      buf_data;
    logic            pop;

    load_state_t     state_q;
    load_state_t     state_d;
    logic [1:0]      byte_cnt_q;
    logic [31:0]     asm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0] remain_q;

    logic [31:0]     assembled;
    logic            load_byte;
    logic            group_done;
    logic            len_zero;
    logic            len_too_big;
    logic            write_last;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .uart_rx_i    (uart_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_frame_err)
    );

    // Buffer handshake and byte-assembly decode.
    always_comb begin
        pop         = buf_full && (state_q != S_WRITE);
        load_byte   = pop && ((state_q == S_LEN) || (state_q == S_DATA));
        assembled   = {buf_data, asm_q[31:8]};
        group_done  = load_byte &&
                      (byte_cnt_q == ((state_q == S_LEN) ? LEN_LAST : WORD_LAST));
        len_zero    = (assembled == 32'd0);
        len_too_big = ({1'b0, assembled} > CAPACITY);
        write_last  = (remain_q == (ADDR_W+1)'(1));
    end

    // Skid buffer occupancy and sticky receive error flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            buf_full      <= 1'b0;
            overrun_err_o <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            buf_full <= rx_valid || (buf_full && !pop);
            if (rx_valid && buf_full && !pop) overrun_err_o <= 1'b1;
            if (rx_frame_err) frame_err_o <= 1'b1;
        end
    end

    // Skid buffer payload; a byte arriving into a full, stalled buffer is dropped.
    always_ff @(posedge wb_clk_i) begin
        if (rx_valid && (!buf_full || pop)) buf_data <= rx_byte;
    end

    // Loader state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_LEN;
        else          state_q <= state_d;
    end

    // Loader next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (group_done) begin
                    if (len_zero)         state_d = S_DONE;
                    else if (len_too_big) state_d = S_ERR;
                    else                  state_d = S_DATA;
                end
            end
            S_DATA:  if (group_done) state_d = S_WRITE;
            S_WRITE: if (mem_ack_i) state_d = write_last ? S_DONE : S_DATA;
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LEN;
        endcase
    end

    // Loader outputs decoded from state.
    always_comb begin
        mem_we_o    = (state_q == S_WRITE);
        core_rst_o  = (state_q != S_DONE);
        prog_done_o = (state_q == S_DONE);
    end

    // Byte counter, assembly register, address and remaining-word count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            len_err_o  <= 1'b0;
        end else begin
            if (load_byte) begin
                asm_q      <= assembled;
                byte_cnt_q <= group_done ? 2'd0 : byte_cnt_q + 1'b1;
            end
            if ((state_q == S_LEN) && group_done) begin
                remain_q <= assembled[ADDR_W:0];
                if (len_too_big) len_err_o <= 1'b1;
            end
            if ((state_q == S_WRITE) && mem_ack_i) begin
                remain_q <= remain_q - 1'b1;
                // Hold the final address so a full image never shows a wrapped address.
                if (!write_last) addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = asm_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: UART driver, image-level model,
// per-cycle compare process that also plays the memory acknowledge side.
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int AW  = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk;
    logic          wb_rst_i;
    logic          uart_rx_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_ack_i;
    logic          core_rst_o;
    logic          prog_done_o;
    logic          frame_err_o;
    logic          overrun_err_o;
    logic          len_err_o;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (wb_rst_i),
        .uart_rx_i     (uart_rx_i),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .core_rst_o    (core_rst_o),
        .prog_done_o   (prog_done_o),
        .frame_err_o   (frame_err_o),
        .overrun_err_o (overrun_err_o),
        .len_err_o     (len_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state
    logic [7:0] stream[$];
    wr_t        exp_q[$];
    wr_t        act_log[$];
    int         exp_total;
    int         acked;
    bit         model_done;
    bit         done_exact;
    bit         ack_stall;
    bit         random_ack;
    int         ack_wait;
    bit         prev_we;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_data;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Parse the accepted byte stream into the writes the loader must perform.
    task automatic build_model();
        logic [31:0] n;
        logic [31:0] w;
        n = {stream[3], stream[2], stream[1], stream[0]};
        if (n > 32'(1 << AW)) return;
        if (n == 0) done_exact = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            w = {stream[4+4*i+3], stream[4+4*i+2], stream[4+4*i+1], stream[4+4*i]};
            exp_q.push_back(wr_t'{addr: AW'(i), data: w});
        end
        exp_total = int'(n);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
    endtask

    task automatic uart_byte(input logic [7:0] b, input bit stop = 1'b1);
        uart_rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            tick(CPB);
        end
        uart_rx_i = stop;
        tick(CPB);
        uart_rx_i = 1'b1;
        tick(CPB);
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) uart_byte(stream[i]);
    endtask

    task automatic do_reset();
        wb_rst_i   = 1'b1;
        uart_rx_i  = 1'b1;
        exp_q.delete();
        act_log.delete();
        stream.delete();
        exp_total  = 0;
        acked      = 0;
        model_done = 1'b0;
        done_exact = 1'b1;
        ack_stall  = 1'b0;
        tick(3);
        wb_rst_i = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rst_we"},      32'(mem_we_o),      32'd0);
        check({tag, "_rst_addr"},    32'(mem_addr_o),    32'd0);
        check({tag, "_rst_wdata"},   mem_wdata_o,        32'd0);
        check({tag, "_rst_core"},    32'(core_rst_o),    32'd1);
        check({tag, "_rst_done"},    32'(prog_done_o),   32'd0);
        check({tag, "_rst_flags"},   32'({frame_err_o, overrun_err_o, len_err_o}), 32'd0);
    endtask

    task automatic check_flags(input string tag, input bit fe, input bit oe, input bit le);
        check({tag, "_frame_err"},   32'(frame_err_o),   32'(fe));
        check({tag, "_overrun_err"}, 32'(overrun_err_o), 32'(oe));
        check({tag, "_len_err"},     32'(len_err_o),     32'(le));
    endtask

    task automatic wait_writes(input string tag, input int count, input int budget);
        int i;
        i = 0;
        while ((act_log.size() < count || mem_we_o) && i < budget) begin
            tick(1);
            i++;
        end
        check({tag, "_write_timeout"}, 32'(i < budget), 32'd1);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},     32'(prog_done_o), 32'd1);
        check({tag, "_core_rst"}, 32'(core_rst_o),  32'd0);
        check({tag, "_nwrites"},  32'(act_log.size()), 32'(exp_total));
    endtask

    // Per-cycle compare against the model; also drives the memory acknowledge.
    always @(negedge clk) begin
        if (wb_rst_i) begin
            mem_ack_i = 1'b0;
            prev_we   = 1'b0;
            ack_wait  = 0;
        end else begin
            check("core_rst_vs_done", 32'(core_rst_o), 32'(!prog_done_o));
            if (done_exact) check("done_timing", 32'(prog_done_o), 32'(model_done));
            if (exp_q.size() == 0) check("no_write_expected", 32'(mem_we_o), 32'd0);
            if (prev_we && mem_we_o) begin
                check("addr_stable", 32'(mem_addr_o), 32'(prev_addr));
                check("data_stable", mem_wdata_o, prev_data);
            end
            prev_we   = mem_we_o && !mem_ack_i;
            prev_addr = mem_addr_o;
            prev_data = mem_wdata_o;

            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
            end else if (mem_we_o && !ack_stall) begin
                if (ack_wait == 0) begin
                    mem_ack_i = 1'b1;
                    act_log.push_back(wr_t'{addr: mem_addr_o, data: mem_wdata_o});
                    if (exp_q.size() != 0) begin
                        check("write_addr", 32'(mem_addr_o), 32'(exp_q[0].addr));
                        check("write_data", mem_wdata_o, exp_q[0].data);
                        void'(exp_q.pop_front());
                        acked++;
                        if (acked == exp_total) model_done = 1'b1;
                    end
                    ack_wait = random_ack ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    ack_wait--;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  extra;
        logic [31:0] nrand;
        wb_rst_i   = 1'b1;
        uart_rx_i  = 1'b1;
        mem_ack_i  = 1'b0;
        random_ack = 1'b0;
        tick(2);

        // Basic two-word image with immediate ack.
        do_reset();
        check_reset_values("s1");
        stream = '{8'h02, 8'h00, 8'h00, 8'h00};
        push_word(32'h0000_0013);
        push_word(32'hDEAD_BEEF);
        build_model();
        check("s1_model_w0", exp_q[0].data, 32'h0000_0013);
        send_range(0, stream.size());
        wait_writes("s1", 2, 400);
        check("s1_log0_addr", 32'(act_log[0].addr), 32'd0);
        check("s1_log0_data", act_log[0].data, 32'h0000_0013);
        check("s1_log1_addr", 32'(act_log[1].addr), 32'd1);
        check("s1_log1_data", act_log[1].data, 32'hDEAD_BEEF);
        tick(2);
        check_done("s1");
        check_flags("s1", 1'b0, 1'b0, 1'b0);

        // Zero-length image.
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00};
        build_model();
        send_range(0, 4);
        check_done("s2");
        check_flags("s2", 1'b0, 1'b0, 1'b0);

        // Bad stop bit inside a word; the valid bytes still build the word.
        do_reset();
        stream = '{8'h01, 8'h00, 8'h00, 8'h00};
        push_word(32'h1122_3344);
        build_model();
        send_range(0, 6);
        uart_byte(8'hA5, 1'b0);
        send_range(6, 8);
        wait_writes("s3", 1, 400);
        check("s3_log0_data", act_log[0].data, 32'h1122_3344);
        tick(2);
        check_done("s3");
        check_flags("s3", 1'b1, 1'b0, 1'b0);

        // Short low glitch must not start a byte; a following image aligns.
        do_reset();
        uart_rx_i = 1'b0;
        tick(2);
        uart_rx_i = 1'b1;
        tick(3 * CPB);
        check_flags("s4_glitch", 1'b0, 1'b0, 1'b0);
        stream = '{8'h01, 8'h00, 8'h00, 8'h00};
        push_word($urandom());
        build_model();
        send_range(0, 8);
        wait_writes("s4", 1, 400);
        tick(2);
        check_done("s4");
        check_flags("s4", 1'b0, 1'b0, 1'b0);

        // Stalled write with two bytes arriving: second is lost.
        for (int variant = 0; variant < 2; variant++) begin
            do_reset();
            random_ack = 1'b1;
            stream = '{8'h02, 8'h00, 8'h00, 8'h00};
            push_word($urandom());
            push_word($urandom());
            build_model();
            send_range(0, 4);
            ack_stall = 1'b1;
            send_range(4, 9);
            if (variant == 0) begin
                extra = 8'($urandom());
                uart_byte(extra);
            end
            tick(2 * CPB);
            check("s5_stall_we",   32'(mem_we_o),   32'd1);
            check("s5_stall_addr", 32'(mem_addr_o), 32'd0);
            check("s5_stall_data", mem_wdata_o, {stream[7], stream[6], stream[5], stream[4]});
            ack_stall = 1'b0;
            send_range(9, 12);
            wait_writes("s5", 2, 400);
            tick(2);
            check_done("s5");
            check_flags("s5", 1'b0, variant == 0, 1'b0);
        end

        // Header larger than capacity.
        do_reset();
        stream = '{8'h11, 8'h00, 8'h00, 8'h00};
        push_word($urandom());
        build_model();
        send_range(0, 8);
        check("s6_nwrites", 32'(act_log.size()), 32'd0);
        check("s6_core_rst", 32'(core_rst_o),  32'd1);
        check("s6_done",     32'(prog_done_o), 32'd0);
        check_flags("s6", 1'b0, 1'b0, 1'b1);

        // Exactly full memory with random data and ack delays.
        do_reset();
        random_ack = 1'b1;
        stream = '{8'h10, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < (1 << AW); i++) push_word($urandom());
        build_model();
        send_range(0, stream.size());
        wait_writes("s7", 1 << AW, 400);
        check("s7_last_addr", 32'(act_log[(1 << AW) - 1].addr), 32'((1 << AW) - 1));
        tick(2);
        check_done("s7");
        check_flags("s7", 1'b0, 1'b0, 1'b0);

        // Reset mid-image with a partial byte on the line, then a fresh image.
        do_reset();
        stream = '{8'h03, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) push_word($urandom());
        build_model();
        send_range(0, 8);
        wait_writes("s8a", 1, 400);
        send_range(8, 10);
        uart_rx_i = 1'b0;
        tick(3 * CPB);
        do_reset();
        check_reset_values("s8");
        stream = '{8'h01, 8'h00, 8'h00, 8'h00};
        push_word(32'hCAFE_F00D);
        build_model();
        send_range(0, 8);
        wait_writes("s8", 1, 400);
        check("s8_log0_addr", 32'(act_log[0].addr), 32'd0);
        check("s8_log0_data", act_log[0].data, 32'hCAFE_F00D);
        tick(2);
        check_done("s8");

        // Random short images.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            random_ack = 1'b1;
            nrand = 32'($urandom_range(1, 5));
            stream.delete();
            push_word(nrand);
            for (int i = 0; i < int'(nrand); i++) push_word($urandom());
            build_model();
            send_range(0, stream.size());
            wait_writes("rnd", int'(nrand), 400);
            tick(2);
            check_done("rnd");
            check_flags("rnd", 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

User-project-side boot loader for the BrqRV_EB1 Caravel integration. It receives a program image as 8N1 UART bytes on an mprj_io input pin and assembles little-endian 32-bit words. It writes them sequentially into core instruction memory through a request/acknowledge write port. When the image is complete it releases the core reset and raises `prog_done_o`, which drives the `mprj_ready` pin (mprj_io[37]) seen by the host or testbench.

## Interface
Parameters:
- `CLKS_PER_BIT`, 347, wb_clk_i cycles per UART bit (40 MHz / 115200). Must be ≥ 4.
- `ADDR_W`, 12, word-address width; capacity is 2**ADDR_W words.

Ports:
- `wb_clk_i  in  1  single clock`
- `wb_rst_i  in  1  synchronous, active-high reset`
- `uart_rx_i  in  1  serial input, idle high, asynchronous to wb_clk_i`
- `mem_we_o  out  1  write request, held until acknowledged`
- `mem_addr_o  out  ADDR_W  word address`
- `mem_wdata_o  out  32  write data`
- `mem_ack_i  in  1  write accepted this cycle`
- `core_rst_o  out  1  core reset, high until load completes`
- `prog_done_o  out  1  load complete; drives mprj_io[37]`
- `frame_err_o  out  1  sticky: stop bit sampled low`
- `overrun_err_o  out  1  sticky: received byte lost`
- `len_err_o  out  1  sticky: header length exceeds capacity`

## Operation
- Image format: 4-byte little-endian word count N, followed by N words of 4 bytes each, little-endian.
- RX path:
  - `uart_rx_i` passes through a 2-FF synchronizer.
  - In idle, a synchronized low starts the bit timer. At CLKS_PER_BIT/2 the line is re-sampled; if it is high, the event is a false start and the RX returns to idle.
  - 8 data bits are sampled LSB first at CLKS_PER_BIT intervals, then the stop bit.
  - Stop bit = 1: `byte_valid` pulses for 1 cycle with the byte.
  - Stop bit = 0: `frame_err_o` is set, the byte is dropped and byte counters are unchanged, and the RX returns to idle.
- Byte buffer: one-entry skid register between RX and loader.
  - A byte is consumed in any state other than S_WRITE.
  - If a new byte arrives while the buffer is still full, `overrun_err_o` is set and the new byte is dropped.
- Loader FSM:
  - S_LEN: shift 4 bytes into the length register.
    - N == 0 → S_DONE.
    - N > 2**ADDR_W → set `len_err_o`, go to S_ERR.
    - Otherwise → S_DATA.
  - S_DATA: shift 4 bytes into the word register (byte k goes to bits 8k+7:8k), then → S_WRITE.
  - S_WRITE: assert `mem_we_o` with `mem_addr_o` and `mem_wdata_o` stable. On `mem_ack_i`:
    - drop `mem_we_o`, increment the address, decrement the remaining count;
    - remaining == 0 → S_DONE, else → S_DATA.
  - S_DONE: `core_rst_o`=0, `prog_done_o`=1. All further bytes are ignored. Terminal until reset.
  - S_ERR: `core_rst_o` stays 1, no writes. Terminal until reset.
- Address arithmetic: ADDR_W bits, no wrap is possible because the N ≤ 2**ADDR_W check happens first. N = 2**ADDR_W fills memory exactly. The remaining-word counter is ADDR_W+1 bits wide.
- Reset mid-operation (any state) has the same effect as power-on:
  - FSM returns to S_LEN, address and counters clear, buffer empties;
  - `core_rst_o` goes back to 1 and `prog_done_o` to 0;
  - a partially received UART byte is discarded.

## Timing
- Reset values: `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `core_rst_o`=1, `prog_done_o`=0, all error flags 0.
- `byte_valid` rises 1 cycle after the stop-bit sample.
- After the 4th byte of a word is accepted, `mem_we_o` rises on the next cycle.
- `mem_ack_i` is sampled only while `mem_we_o`=1. `mem_we_o` falls on the cycle after ack. Back-to-back acks are not required.
- `prog_done_o` and `core_rst_o` change on the same cycle: the cycle after the final ack, or the cycle after the 4th length byte when N=0.
- An ack stall up to ~10·CLKS_PER_BIT cycles is absorbed by the skid buffer. Longer stalls risk overrun.

## Structure
- Shared package `brqrv_loader_pkg`:
  - loader state enum (S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR);
  - RX state enum (IDLE, START, DATA, STOP);
  - constants `LEN_BYTES`=4 and `WORD_BYTES`=4.
- One sub-module, `uart_rx_byte`: synchronizer, bit timer and framing. Outputs are `byte_o`, `byte_valid_o`, `frame_err_o`.
- The loader FSM, skid buffer and counters live in the top.

## Test plan
All scenarios use CLKS_PER_BIT=8 and ADDR_W=4, with a bench UART driver.
- Send N=2, then words 0x00000013 and 0xDEADBEEF, with immediate ack → writes (0,0x00000013) and (1,0xDEADBEEF). `prog_done_o` 0→1 and `core_rst_o` 1→0 on the cycle after the 2nd ack.
- Send N=0 → no `mem_we_o` pulse; `prog_done_o`=1 on the cycle after the 4th byte.
- Send a byte with stop bit 0 mid-word, then the correct bytes → `frame_err_o`=1; the word is still written correctly from the valid bytes.
- Drive a 2-cycle low glitch on `uart_rx_i` → no byte and no error flag.
- Hold ack low for 12 bit-times during a write while sending 2 bytes → addr/data stable throughout, `overrun_err_o`=1. With 1 byte only → no overrun, and the next word completes.
- Send N=17 → `len_err_o`=1, no writes, `core_rst_o` stays 1. Separately, assert reset after 1 word of N=3, then resend N=1 with 0xCAFEF00D → write at addr 0 and done.
